pong_round_ctrl: RTL

PONG_ROUND_CTRL -- requirements
Module: pong_round_ctrl

---
 rtl/pong_pkg.sv | 24 ++
 rtl/frame_timer.sv | 20 ++
 rtl/pong_round_ctrl.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/pong_pkg.sv
// rtl/pong_pkg.sv - shared types and constants for the pong round controller.
package pong_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SERVE = 3'd1,
    ST_PLAY  = 3'd2,
    ST_POINT = 3'd3,
    ST_OVER  = 3'd4
  } state_t;

  localparam logic [1:0] WINNER_NONE  = 2'b00;
  localparam logic [1:0] WINNER_LEFT  = 2'b01;
  localparam logic [1:0] WINNER_RIGHT = 2'b10;

  // Position of the frame_tick pulse in the 800x600 raster.
  localparam int FRAME_LAST_ROW = 599;
  localparam int FRAME_LAST_COL = 799;

  function automatic logic [3:0] score_inc(input logic [3:0] score, input logic [3:0] limit);
    return (score >= limit) ? limit : score + 4'd1;
  endfunction

endpackage

// File: rtl/frame_timer.sv
// rtl/frame_timer.sv - 8-bit frame counter, saturating at 255, cleared on request.
module frame_timer (
  input  logic       clock,
  input  logic       reset,
  input  logic       clear,
  input  logic       tick,
  output logic [7:0] count
);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (tick && (count != 8'hFF)) begin
      count <= count + 8'd1;
    end
  end

endmodule

// File: rtl/pong_round_ctrl.sv
// rtl/pong_round_ctrl.sv - pong round/score sequencer; PONG_OVER_BLINK_EN blinks paddles in OVER.
module pong_round_ctrl #(
  parameter int SERVE_FRAMES = 60,
  parameter int POINT_FRAMES = 90,
  parameter int WIN_SCORE    = 7
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       start,
  input  logic       miss_left,
  input  logic       miss_right,
  output logic       up_p,
  output logic       center,
  output logic       draw_p,
  output logic       ball_run,
  output logic [3:0] score_l,
  output logic [3:0] score_r,
  output logic [1:0] winner,
  output logic [2:0] state
);
  import pong_pkg::*;

  localparam logic [7:0] SERVE_LAST = 8'(SERVE_FRAMES - 1);
  localparam logic [7:0] POINT_LAST = 8'(POINT_FRAMES - 1);
  localparam logic [3:0] WIN        = 4'(WIN_SCORE);

  state_t     cur_state;
  state_t     nxt_state;
  logic [7:0] count;
  logic       start_s1, start_s2, start_s3;
  logic       start_rise;
  logic       flag_l, flag_r;
  logic       eff_l, eff_r;
  logic       state_change;

  // Two flops resynchronise the button; the third remembers the previous level.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      start_s1 <= 1'b0;
      start_s2 <= 1'b0;
      start_s3 <= 1'b0;
    end else begin
      start_s1 <= start;
      start_s2 <= start_s1;
      start_s3 <= start_s2;
    end
  end

  assign start_rise   = start_s2 & ~start_s3;
  assign eff_l        = flag_l | miss_left;
  assign eff_r        = flag_r | miss_right;
  assign state_change = (nxt_state != cur_state);
  assign state        = cur_state;

  frame_timer u_frame_timer (
    .clock (clock),
    .reset (reset),
    .clear (state_change),
    .tick  (frame_tick),
    .count (count)
  );

`ifdef PONG_OVER_BLINK_EN
  logic blink;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      blink <= 1'b1;
    end else if (cur_state != ST_OVER) begin
      blink <= 1'b1;
    end else if (frame_tick && (count[4:0] == 5'h1F) && (count != 8'hFF)) begin
      blink <= ~blink;
    end
  end
`endif

  always_comb begin
    nxt_state = cur_state;
    center    = 1'b0;
    draw_p    = 1'b0;
    up_p      = 1'b0;
    ball_run  = 1'b0;
    case (cur_state)
      ST_IDLE: begin
        center = 1'b1;
        if (start_rise) nxt_state = ST_SERVE;
      end
      ST_SERVE: begin
        center = (count == 8'd0);
        draw_p = 1'b1;
        up_p   = 1'b1;
        if (frame_tick && (count == SERVE_LAST)) nxt_state = ST_PLAY;
      end
      ST_PLAY: begin
        draw_p   = 1'b1;
        up_p     = 1'b1;
        ball_run = 1'b1;
        if (frame_tick && (eff_l || eff_r)) nxt_state = ST_POINT;
      end
      ST_POINT: begin
        draw_p = 1'b1;
        if (frame_tick && (count == POINT_LAST)) begin
          nxt_state = ((score_l == WIN) || (score_r == WIN)) ? ST_OVER : ST_SERVE;
        end
      end
      ST_OVER: begin
`ifdef PONG_OVER_BLINK_EN
        draw_p = blink;
`else
        draw_p = 1'b1;
`endif
        if (start_rise) nxt_state = ST_IDLE;
      end
      default: nxt_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cur_state <= ST_IDLE;
    end else begin
      cur_state <= nxt_state;
    end
  end

  // Misses are only meaningful while the ball is live; leaving PLAY forgets them.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      flag_l <= 1'b0;
      flag_r <= 1'b0;
    end else if ((cur_state == ST_PLAY) && (nxt_state == ST_PLAY)) begin
      flag_l <= eff_l;
      flag_r <= eff_r;
    end else begin
      flag_l <= 1'b0;
      flag_r <= 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      score_l <= 4'd0;
      score_r <= 4'd0;
      winner  <= WINNER_NONE;
    end else if ((cur_state == ST_IDLE) && (nxt_state == ST_SERVE)) begin
      score_l <= 4'd0;
      score_r <= 4'd0;
      winner  <= WINNER_NONE;
    end else if ((cur_state == ST_PLAY) && (nxt_state == ST_POINT)) begin
      // A left miss is a point for the right player and vice versa; both is void.
      if (eff_l && !eff_r) score_r <= score_inc(score_r, WIN);
      if (eff_r && !eff_l) score_l <= score_inc(score_l, WIN);
    end else if ((cur_state == ST_POINT) && (nxt_state == ST_OVER)) begin
      winner <= (score_l == WIN) ? WINNER_LEFT : WINNER_RIGHT;
    end
  end

endmodule
